// File: rtl/fusion_pkg.sv
// fusion_pkg: shared types and constants for the Fusion Unit controller.
// Mode encodings, FSM states and datapath widths.
package fusion_pkg;

    localparam int NUM_BB       = 16;
    localparam int SUM_W        = 20;
    localparam int SHIFT_CODE_W = 3;

    typedef enum logic [1:0] {
        MODE_8X8 = 2'b00,
        MODE_4X4 = 2'b01,
        MODE_2X2 = 2'b10,
        MODE_ILL = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

endpackage

// File: rtl/fusion_pack.sv
// fusion_pack: expands packed operands into per-bitbrick 2-bit slices,
// shift codes and row/column sign flags. Purely combinational.
module fusion_pack
    import fusion_pkg::*;
(
    input  mode_e       mode,
    input  logic        sgn,
    input  logic [31:0] in_x,
    input  logic [31:0] in_y,
    output logic [31:0] pe_x,
    output logic [31:0] pe_y,
    output logic [47:0] signal,
    output logic [3:0]  sign_x,
    output logic [3:0]  sign_y
);

    // Per brick: pick digit j of the x element and digit l of the y element.
    always_comb begin
        pe_x   = '0;
        pe_y   = '0;
        signal = '0;
        sign_x = '0;
        sign_y = '0;
        for (int i = 0; i < NUM_BB; i++) begin : g_bb
            int r, c, j, l, e, dmax;
            logic [4:0] xb, yb;
            r    = i / 4;
            c    = i % 4;
            j    = 0;
            l    = 0;
            e    = 0;
            dmax = 0;
            case (mode)
                MODE_8X8: begin
                    j    = r;
                    l    = c;
                    e    = 0;
                    dmax = 3;
                end
                MODE_4X4: begin
                    j    = r % 2;
                    l    = c % 2;
                    e    = 2 * (r / 2) + (c / 2);
                    dmax = 1;
                end
                MODE_2X2: begin
                    j    = 0;
                    l    = 0;
                    e    = i;
                    dmax = 0;
                end
                default: begin
                    j    = 0;
                    l    = 0;
                    e    = 0;
                    dmax = -1;
                end
            endcase
            xb = 5'(e * 2 * (dmax + 1) + 2 * j);
            yb = 5'(e * 2 * (dmax + 1) + 2 * l);
            if (dmax >= 0) begin
                pe_x[2*i +: 2]   = in_x[xb +: 2];
                pe_y[2*i +: 2]   = in_y[yb +: 2];
                signal[3*i +: 3] = SHIFT_CODE_W'(j + l);
                if (j == dmax) sign_x[r] = sgn;
                if (l == dmax) sign_y[c] = sgn;
            end
        end
    end

endmodule

// File: rtl/fusion_ctrl.sv
// fusion_ctrl: job sequencer for one Fusion Unit PE with accumulation loop.
// Optional FUSION_CTRL_PERF_EN adds busy/stall performance counters.
module fusion_ctrl
    import fusion_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       cfg_mode,
    input  logic             cfg_signed,
    input  logic [LEN_W-1:0] cfg_len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_x,
    input  logic [31:0]      in_y,
    output logic [31:0]      pe_x,
    output logic [31:0]      pe_y,
    output logic [47:0]      pe_signal,
    output logic [3:0]       pe_sign_x,
    output logic [3:0]       pe_sign_y,
    output logic [SUM_W-1:0] pe_prev_sum,
    input  logic [SUM_W-1:0] pe_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] out_result
`ifdef FUSION_CTRL_PERF_EN
    ,
    output logic [31:0]      perf_busy_cnt,
    output logic [31:0]      perf_stall_cnt
`endif
);

    state_e             state_q, state_d;
    mode_e              mode_q, mode_d;
    logic               sgn_q, sgn_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               v1_q, v1_d;
    logic               v2_q;
    logic [SUM_W-1:0]   acc_q, acc_d;
    logic [31:0]        px_q, px_d, py_q, py_d;
    logic [47:0]        sig_q, sig_d;
    logic [3:0]         sx_q, sx_d, sy_q, sy_d;

    logic [31:0]        pk_x, pk_y;
    logic [47:0]        pk_sig;
    logic [3:0]         pk_sx, pk_sy;

    fusion_pack u_pack (
        .mode   (mode_q),
        .sgn    (sgn_q),
        .in_x   (in_x),
        .in_y   (in_y),
        .pe_x   (pk_x),
        .pe_y   (pk_y),
        .signal (pk_sig),
        .sign_x (pk_sx),
        .sign_y (pk_sy)
    );

    assign busy        = (state_q != IDLE);
    assign in_ready    = (state_q == RUN);
    assign out_valid   = (state_q == DONE);
    assign out_result  = acc_q;
    assign pe_prev_sum = acc_q;
    assign pe_x        = px_q;
    assign pe_y        = py_q;
    assign pe_signal   = sig_q;
    assign pe_sign_x   = sx_q;
    assign pe_sign_y   = sy_q;

    // Next state, job latching, beat capture and accumulation.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        sgn_d   = sgn_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        v1_d    = 1'b0;
        acc_d   = acc_q;
        px_d    = px_q;
        py_d    = py_q;
        sig_d   = sig_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        if (v2_q) acc_d = pe_sum;
        case (state_q)
            IDLE: begin
                if (start && cfg_mode != MODE_ILL
                    && cfg_len != '0) begin
                    mode_d  = mode_e'(cfg_mode);
                    sgn_d   = cfg_signed;
                    len_d   = cfg_len;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (in_valid) begin
                    v1_d  = 1'b1;
                    px_d  = pk_x;
                    py_d  = pk_y;
                    sig_d = pk_sig;
                    sx_d  = pk_sx;
                    sy_d  = pk_sy;
                    cnt_d = cnt_q + LEN_W'(1);
                    if (cnt_q == len_q - LEN_W'(1))
                        state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (v2_q && !v1_q) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and pipeline registers; reset drops in-flight beats.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            mode_q  <= MODE_8X8;
            sgn_q   <= 1'b0;
            len_q   <= '0;
            cnt_q   <= '0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            acc_q   <= '0;
            px_q    <= '0;
            py_q    <= '0;
            sig_q   <= '0;
            sx_q    <= '0;
            sy_q    <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            sgn_q   <= sgn_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            v1_q    <= v1_d;
            v2_q    <= v1_q;
            acc_q   <= acc_d;
            px_q    <= px_d;
            py_q    <= py_d;
            sig_q   <= sig_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
        end
    end

`ifdef FUSION_CTRL_PERF_EN
    logic [31:0] bcnt_q, bcnt_d, scnt_q, scnt_d;

    assign perf_busy_cnt  = bcnt_q;
    assign perf_stall_cnt = scnt_q;

    // Busy cycles, plus input starvation in RUN and output backpressure in DONE.
    always_comb begin
        bcnt_d = bcnt_q;
        scnt_d = scnt_q;
        if (busy) bcnt_d = bcnt_q + 32'd1;
        if ((state_q == RUN && !in_valid)
            || (state_q == DONE && !out_ready))
            scnt_d = scnt_q + 32'd1;
    end

    // Counters wrap and clear only on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcnt_q <= '0;
            scnt_q <= '0;
        end else begin
            bcnt_q <= bcnt_d;
            scnt_q <= scnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_fusion_ctrl.sv
// tb_fusion_ctrl: scoreboard bench for fusion_ctrl with a behavioural PE.
// Expected dot products come from element arithmetic, not brick slices.
module tb_fusion_ctrl;
    import fusion_pkg::*;

    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [1:0]       cfg_mode;
    logic             cfg_signed;
    logic [LEN_W-1:0] cfg_len;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_x, in_y;
    logic [31:0]      pe_x, pe_y;
    logic [47:0]      pe_signal;
    logic [3:0]       pe_sign_x, pe_sign_y;
    logic [19:0]      pe_prev_sum;
    logic [19:0]      pe_sum;
    logic             out_valid;
    logic             out_ready;
    logic [19:0]      out_result;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int t0, t1;
    logic [19:0] sb_q[$];
    logic [19:0] prod_q = '0;

    always #5 clk = ~clk;

    fusion_ctrl #(.LEN_W(LEN_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .cfg_mode    (cfg_mode),
        .cfg_signed  (cfg_signed),
        .cfg_len     (cfg_len),
        .busy        (busy),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_x        (in_x),
        .in_y        (in_y),
        .pe_x        (pe_x),
        .pe_y        (pe_y),
        .pe_signal   (pe_signal),
        .pe_sign_x   (pe_sign_x),
        .pe_sign_y   (pe_sign_y),
        .pe_prev_sum (pe_prev_sum),
        .pe_sum      (pe_sum),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result)
    );

    function automatic int brick_sum(
        logic [31:0] x, logic [31:0] y, logic [47:0] sg,
        logic [3:0] sx, logic [3:0] sy);
        int s;
        s = 0;
        for (int i = 0; i < 16; i++) begin
            int a, b, k;
            a = int'(x[2*i +: 2]);
            b = int'(y[2*i +: 2]);
            k = int'(sg[3*i +: 3]);
            if (sx[i/4] && a >= 2) a -= 4;
            if (sy[i%4] && b >= 2) b -= 4;
            s += a * b * (1 << (2 * k));
        end
        return s;
    endfunction

    function automatic int dot(
        logic [1:0] m, logic s, logic [31:0] x, logic [31:0] y);
        int n, w, acc;
        acc = 0;
        case (m)
            2'b00:   begin n = 1;  w = 8; end
            2'b01:   begin n = 4;  w = 4; end
            default: begin n = 16; w = 2; end
        endcase
        for (int k = 0; k < n; k++) begin
            int a, b;
            a = int'((x >> (k * w)) & ((32'd1 << w) - 1));
            b = int'((y >> (k * w)) & ((32'd1 << w) - 1));
            if (s && a >= (1 << (w - 1))) a -= (1 << w);
            if (s && b >= (1 << (w - 1))) b -= (1 << w);
            acc += a * b;
        end
        return acc;
    endfunction

    // Behavioural PE: products registered, sum combinational.
    always @(posedge clk)
        prod_q <= 20'(brick_sum(pe_x, pe_y, pe_signal,
                                pe_sign_x, pe_sign_y));
    assign pe_sum = pe_prev_sum + prod_q;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Scoreboard pop on each result handshake.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb_q.size() == 0)
                chk("sb_extra", 64'(sb_q.size()), 64'd1);
            else
                chk("result", 64'(out_result), 64'(sb_q.pop_front()));
        end
    end

    task automatic push_exp(
        logic [1:0] m, logic s, int len, logic [31:0] x, logic [31:0] y);
        sb_q.push_back(20'(len * dot(m, s, x, y)));
    endtask

    task automatic start_job(logic [1:0] m, logic s, logic [7:0] len);
        start      = 1'b1;
        cfg_mode   = m;
        cfg_signed = s;
        cfg_len    = len;
        @(posedge clk); #1;
        start      = 1'b0;
    endtask

    task automatic send_beats(
        int len, logic [31:0] x, logic [31:0] y, int gap,
        output int tf);
        tf = 0;
        for (int b = 0; b < len; b++) begin
            int k;
            k        = 0;
            in_valid = 1'b1;
            in_x     = x;
            in_y     = y;
            do begin
                @(negedge clk);
                k++;
            end while (!in_ready && k < 50);
            if (!in_ready) chk("in_ready_tmo", 64'(in_ready), 64'd1);
            if (b == 0) tf = cyc;
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (b < len - 1)
                repeat (gap) begin @(posedge clk); #1; end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int tf);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!out_valid && k < 100);
        if (!out_valid) chk("out_tmo", 64'(out_valid), 64'd1);
        tf = cyc;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        if (busy) chk("idle_tmo", 64'(busy), 64'd0);
    endtask

    task automatic check_reset_vals();
        chk("rst_ctl", 64'({busy, in_ready, out_valid}), 64'd0);
        chk("rst_res", 64'(out_result), 64'd0);
        chk("rst_prev", 64'(pe_prev_sum), 64'd0);
        chk("rst_pexy", {pe_x, pe_y}, 64'd0);
        chk("rst_sig", 64'({pe_signal, pe_sign_x, pe_sign_y}), 64'd0);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        cfg_mode   = 2'b00;
        cfg_signed = 1'b0;
        cfg_len    = '0;
        in_valid   = 1'b0;
        in_x       = '0;
        in_y       = '0;
        out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals();
        reset = 1'b0;
        @(posedge clk); #1;

        // 8x8 unsigned 200*100
        push_exp(2'b00, 1'b0, 1, 32'd200, 32'd100);
        start_job(2'b00, 1'b0, 8'd1);
        send_beats(1, 32'd200, 32'd100, 0, t0);
        chk("t1_code15", 64'(pe_signal[47:45]), 64'd6);
        chk("t1_code0", 64'(pe_signal[2:0]), 64'd0);
        wait_out(t1);
        wait_idle();

        // 8x8 signed -3*5
        push_exp(2'b00, 1'b1, 1, 32'hFD, 32'h05);
        start_job(2'b00, 1'b1, 8'd1);
        send_beats(1, 32'hFD, 32'h05, 0, t0);
        chk("t2_sx", 64'(pe_sign_x), 64'h8);
        chk("t2_sy", 64'(pe_sign_y), 64'h8);
        wait_out(t1);
        wait_idle();

        // 4x4 unsigned, two beats, latency
        push_exp(2'b01, 1'b0, 2, 32'h4321, 32'h1111);
        start_job(2'b01, 1'b0, 8'd2);
        send_beats(2, 32'h4321, 32'h1111, 0, t0);
        wait_out(t1);
        chk("t3_lat", 64'(t1 - t0 + 1), 64'd5);
        wait_idle();

        // 2x2 signed, all -1 times all +1
        push_exp(2'b10, 1'b1, 1, 32'hFFFFFFFF, 32'h55555555);
        start_job(2'b10, 1'b1, 8'd1);
        send_beats(1, 32'hFFFFFFFF, 32'h55555555, 0, t0);
        chk("t4_sx", 64'(pe_sign_x), 64'hF);
        chk("t4_sy", 64'(pe_sign_y), 64'hF);
        wait_out(t1);
        wait_idle();

        // 8x8 len 3 with gaps, ignored start, backpressure
        out_ready = 1'b0;
        push_exp(2'b00, 1'b0, 3, 32'd2, 32'd2);
        start_job(2'b00, 1'b0, 8'd3);
        start_job(2'b10, 1'b1, 8'd1);
        send_beats(3, 32'd2, 32'd2, 2, t0);
        wait_out(t1);
        for (int i = 0; i < 5; i++) begin
            chk("t5_hold_v", 64'(out_valid), 64'd1);
            chk("t5_hold_r", 64'(out_result), 64'd12);
            @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        chk("t5_no_restart", 64'(busy), 64'd0);

        // illegal mode and zero length
        start_job(2'b11, 1'b0, 8'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("t6_ill_mode", 64'(busy), 64'd0);
        start_job(2'b00, 1'b0, 8'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("t6_len0", 64'(busy), 64'd0);

        // reset mid-job, then a clean job
        start_job(2'b00, 1'b0, 8'd4);
        send_beats(1, 32'h11, 32'h22, 0, t0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_reset_vals();
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        push_exp(2'b00, 1'b0, 1, 32'd3, 32'd3);
        start_job(2'b00, 1'b0, 8'd1);
        send_beats(1, 32'd3, 32'd3, 0, t0);
        wait_out(t1);
        wait_idle();

        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
